// File: rtl/cdc_hs_pkg.sv
// cdc_hs_pkg: shared types for the toggle handshake transmitter.
// Holds the tx state enum and counter width helper.
package cdc_hs_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETUP    = 2'd1,
    WAIT_ACK = 2'd2
  } cdc_hs_tx_state_t;

  // Width needed to hold 0..max_val, never below 1 bit.
  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/cdc_handshake_tx.sv
// cdc_handshake_tx: source side of a two-phase req/ack word crossing.
// Ports: clk, rst (sync high); s_valid/s_ready/s_data stream in;
//   cdc_data/cdc_req toward the far domain; cdc_ack (already
//   synchronized); busy; timeout (sticky) cleared by err_clr.
module cdc_handshake_tx
  import cdc_hs_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int SETUP_CYCLES = 2,
  parameter int ACK_TIMEOUT  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  input  logic [WIDTH-1:0] s_data,
  output logic             s_ready,
  output logic [WIDTH-1:0] cdc_data,
  output logic             cdc_req,
  input  logic             cdc_ack,
  output logic             busy,
  output logic             timeout,
  input  logic             err_clr
);

  localparam int SCW = cnt_w(SETUP_CYCLES);
  localparam int TCW = cnt_w(ACK_TIMEOUT);

  localparam logic [SCW-1:0] S_LAST = SCW'(SETUP_CYCLES);
  localparam logic [SCW-1:0] S_ONE  = SCW'(1);
  localparam logic [TCW-1:0] T_LAST = TCW'(ACK_TIMEOUT);
  localparam logic [TCW-1:0] T_ONE  = TCW'(1);
  // Count value one edge before the timeout fires.
  localparam logic [TCW-1:0] T_PRE  =
    TCW'((ACK_TIMEOUT == 0) ? 0 : ACK_TIMEOUT - 1);

  cdc_hs_tx_state_t state, state_nxt;
  logic [SCW-1:0]   scnt, scnt_nxt;
  logic [TCW-1:0]   tcnt, tcnt_nxt;
  logic             req_q, req_nxt;
  logic             to_q, to_nxt;
  logic             to_set;
  logic             ack_match;
  logic             accept;

  assign ack_match = (cdc_ack == req_q);
  assign s_ready   = (state == IDLE) && ack_match;
  assign accept    = s_valid && s_ready;
  assign busy      = (state != IDLE);
  assign cdc_req   = req_q;
  assign timeout   = to_q;

  always_comb begin
    state_nxt = state;
    scnt_nxt  = scnt;
    tcnt_nxt  = tcnt;
    req_nxt   = req_q;
    to_set    = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (SETUP_CYCLES == 0) begin
            state_nxt = WAIT_ACK;
            req_nxt   = ~req_q;
            tcnt_nxt  = '0;
          end else begin
            // The accept edge is the first setup edge.
            state_nxt = SETUP;
            scnt_nxt  = S_ONE;
          end
        end
      end
      SETUP: begin
        if (scnt == S_LAST) begin
          state_nxt = WAIT_ACK;
          req_nxt   = ~req_q;
          tcnt_nxt  = '0;
        end else begin
          scnt_nxt = scnt + S_ONE;
        end
      end
      WAIT_ACK: begin
        if (tcnt != T_LAST) begin
          tcnt_nxt = tcnt + T_ONE;
          to_set   = (ACK_TIMEOUT != 0) && (tcnt == T_PRE);
        end
        if (ack_match) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    // A fresh timeout beats a simultaneous clear.
    to_nxt = to_set ? 1'b1 : (err_clr ? 1'b0 : to_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      scnt  <= '0;
      tcnt  <= '0;
      req_q <= 1'b0;
      to_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      scnt  <= scnt_nxt;
      tcnt  <= tcnt_nxt;
      req_q <= req_nxt;
      to_q  <= to_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cdc_data <= '0;
    end else if (accept) begin
      cdc_data <= s_data;
    end
  end

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// tb_cdc_handshake_tx: directed + random bench for cdc_handshake_tx.
// Three configurations checked every cycle against an event-time model.
module tb_cdc_handshake_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int n = 0;

  logic [2:0]  rst_i;
  logic [2:0]  vld_i;
  logic [2:0]  clr_i;
  logic [31:0] dat_i [3];
  logic        ack0;
  logic        ack2;
  logic [2:0]  lb = 3'b000;

  logic [2:0]  rdy_o;
  logic [2:0]  req_o;
  logic [2:0]  busy_o;
  logic [2:0]  to_o;
  logic [31:0] d0;
  logic [15:0] d1;
  logic [7:0]  d2;

  cdc_handshake_tx #(
    .WIDTH(32), .SETUP_CYCLES(2), .ACK_TIMEOUT(8)
  ) u0 (
    .clk(clk), .rst(rst_i[0]),
    .s_valid(vld_i[0]), .s_data(dat_i[0]),
    .s_ready(rdy_o[0]), .cdc_data(d0),
    .cdc_req(req_o[0]), .cdc_ack(ack0),
    .busy(busy_o[0]), .timeout(to_o[0]),
    .err_clr(clr_i[0])
  );

  cdc_handshake_tx #(
    .WIDTH(16), .SETUP_CYCLES(0), .ACK_TIMEOUT(0)
  ) u1 (
    .clk(clk), .rst(rst_i[1]),
    .s_valid(vld_i[1]), .s_data(dat_i[1][15:0]),
    .s_ready(rdy_o[1]), .cdc_data(d1),
    .cdc_req(req_o[1]), .cdc_ack(lb[2]),
    .busy(busy_o[1]), .timeout(to_o[1]),
    .err_clr(clr_i[1])
  );

  cdc_handshake_tx #(
    .WIDTH(8), .SETUP_CYCLES(3), .ACK_TIMEOUT(5)
  ) u2 (
    .clk(clk), .rst(rst_i[2]),
    .s_valid(vld_i[2]), .s_data(dat_i[2][7:0]),
    .s_ready(rdy_o[2]), .cdc_data(d2),
    .cdc_req(req_o[2]), .cdc_ack(ack2),
    .busy(busy_o[2]), .timeout(to_o[2]),
    .err_clr(clr_i[2])
  );

  // Loopback receiver for u1: ack is req delayed by three flops.
  always_ff @(posedge clk) lb <= {lb[1:0], req_o[1]};

  // Reference model: a transfer is described by the edge numbers at
  // which its request toggles and its wait began.
  bit          m_busy [3];
  bit          m_req  [3];
  bit          m_to   [3];
  logic [31:0] m_data [3];
  int          m_tog  [3];
  int          m_ws   [3];

  bit          sv [3];
  bit          sr [3];
  bit          sc [3];
  bit          sa [3];
  logic [31:0] sd [3];

  function automatic int s_cfg(input int i);
    return (i == 0) ? 2 : ((i == 1) ? 0 : 3);
  endfunction

  function automatic int t_cfg(input int i);
    return (i == 0) ? 8 : ((i == 1) ? 0 : 5);
  endfunction

  function automatic logic [31:0] mask(input int i);
    return (i == 0) ? 32'hFFFF_FFFF :
           ((i == 1) ? 32'h0000_FFFF : 32'h0000_00FF);
  endfunction

  function automatic logic ack_of(input int i);
    return (i == 0) ? ack0 : ((i == 1) ? lb[2] : ack2);
  endfunction

  function automatic logic [31:0] dout(input int i);
    return (i == 0) ? d0 : ((i == 1) ? {16'h0, d1} : {24'h0, d2});
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (edge %0d)", tag, got, exp, n);
    end
  endtask

  task automatic model_step(input int i);
    bit fire;
    if (sr[i]) begin
      m_busy[i] = 0;
      m_req[i]  = 0;
      m_to[i]   = 0;
      m_data[i] = '0;
      m_tog[i]  = -1;
      m_ws[i]   = -1;
    end else begin
      fire = (m_ws[i] >= 0) && (t_cfg(i) != 0) &&
             ((n - m_ws[i]) == t_cfg(i));
      if (fire) m_to[i] = 1;
      else if (sc[i]) m_to[i] = 0;
      if (m_ws[i] >= 0) begin
        if (sa[i] == m_req[i]) begin
          m_busy[i] = 0;
          m_ws[i]   = -1;
        end
      end else if (m_tog[i] == n) begin
        m_req[i] = ~m_req[i];
        m_ws[i]  = n;
        m_tog[i] = -1;
      end else if (!m_busy[i] && sv[i] && (sa[i] == m_req[i])) begin
        m_data[i] = sd[i] & mask(i);
        m_busy[i] = 1;
        if (s_cfg(i) == 0) begin
          m_req[i] = ~m_req[i];
          m_ws[i]  = n;
        end else begin
          m_tog[i] = n + s_cfg(i);
        end
      end
    end
  endtask

  task automatic check_all(input int i);
    string p;
    p = $sformatf("u%0d", i);
    check({p, " ready"}, {31'h0, rdy_o[i]},
          {31'h0, !m_busy[i] && (ack_of(i) == m_req[i])});
    check({p, " busy"}, {31'h0, busy_o[i]}, {31'h0, m_busy[i]});
    check({p, " req"}, {31'h0, req_o[i]}, {31'h0, m_req[i]});
    check({p, " timeout"}, {31'h0, to_o[i]}, {31'h0, m_to[i]});
    check({p, " data"}, dout(i), m_data[i]);
  endtask

  // Inputs are driven at the falling edge; the model consumes them at
  // the rising edge and outputs are compared at the next falling edge.
  task automatic tick();
    for (int i = 0; i < 3; i++) begin
      sv[i] = vld_i[i];
      sr[i] = rst_i[i];
      sc[i] = clr_i[i];
      sd[i] = dat_i[i];
      sa[i] = ack_of(i);
    end
    @(posedge clk);
    n++;
    for (int i = 0; i < 3; i++) model_step(i);
    @(negedge clk);
    for (int i = 0; i < 3; i++) check_all(i);
  endtask

  logic [15:0] words [4];

  initial begin
    rst_i = 3'b111;
    vld_i = '0;
    clr_i = '0;
    ack0  = 1'b0;
    ack2  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      dat_i[i] = '0;
      m_tog[i] = -1;
      m_ws[i]  = -1;
    end
    tick();
    tick();
    rst_i = 3'b000;

    check("rst req", {31'h0, req_o[0]}, 32'd0);
    check("rst data", d0, 32'd0);
    check("rst busy", {31'h0, busy_o[0]}, 32'd0);
    check("rst timeout", {31'h0, to_o[0]}, 32'd0);
    check("rst ready", {31'h0, rdy_o[0]}, 32'd1);

    // Single word, two setup cycles.
    vld_i[0] = 1'b1;
    dat_i[0] = 32'hDEAD_BEEF;
    tick();
    vld_i[0] = 1'b0;
    dat_i[0] = 32'h0BAD_F00D;
    check("t1 data k", d0, 32'hDEAD_BEEF);
    check("t1 req k", {31'h0, req_o[0]}, 32'd0);
    check("t1 busy k", {31'h0, busy_o[0]}, 32'd1);
    tick();
    check("t1 req k+1", {31'h0, req_o[0]}, 32'd0);
    tick();
    check("t1 req k+2", {31'h0, req_o[0]}, 32'd1);
    check("t1 data hold", d0, 32'hDEAD_BEEF);
    repeat (4) tick();
    check("t1 ready wait", {31'h0, rdy_o[0]}, 32'd0);
    ack0 = 1'b1;
    tick();
    check("t1 ready ack", {31'h0, rdy_o[0]}, 32'd1);
    check("t1 busy ack", {31'h0, busy_o[0]}, 32'd0);

    // Reset while waiting, acknowledge held high.
    vld_i[0] = 1'b1;
    dat_i[0] = 32'hA5A5_A5A5;
    tick();
    vld_i[0] = 1'b0;
    tick();
    tick();
    check("t4 req wait", {31'h0, req_o[0]}, 32'd0);
    check("t4 busy wait", {31'h0, busy_o[0]}, 32'd1);
    rst_i[0] = 1'b1;
    tick();
    rst_i[0] = 1'b0;
    check("t4 req rst", {31'h0, req_o[0]}, 32'd0);
    check("t4 ready rst", {31'h0, rdy_o[0]}, 32'd0);
    check("t4 data rst", d0, 32'd0);
    vld_i[0] = 1'b1;
    dat_i[0] = 32'h1111_2222;
    tick();
    vld_i[0] = 1'b0;
    check("t4 ready held", {31'h0, rdy_o[0]}, 32'd0);
    check("t4 no accept", {31'h0, busy_o[0]}, 32'd0);
    ack0 = 1'b0;
    tick();
    check("t4 ready back", {31'h0, rdy_o[0]}, 32'd1);

    // Timeout after eight waiting cycles.
    vld_i[0] = 1'b1;
    dat_i[0] = 32'h1234_5678;
    tick();
    vld_i[0] = 1'b0;
    tick();
    tick();
    check("t3 req", {31'h0, req_o[0]}, 32'd1);
    repeat (7) tick();
    check("t3 to early", {31'h0, to_o[0]}, 32'd0);
    tick();
    check("t3 to set", {31'h0, to_o[0]}, 32'd1);
    repeat (3) tick();
    check("t3 to sticky", {31'h0, to_o[0]}, 32'd1);
    check("t3 still busy", {31'h0, busy_o[0]}, 32'd1);
    clr_i[0] = 1'b1;
    ack0 = 1'b1;
    tick();
    clr_i[0] = 1'b0;
    check("t3 to clr", {31'h0, to_o[0]}, 32'd0);
    check("t3 idle", {31'h0, busy_o[0]}, 32'd0);
    check("t3 ready", {31'h0, rdy_o[0]}, 32'd1);

    // Stray acknowledge toggles in IDLE.
    ack0 = 1'b0;
    tick();
    check("t5 ready lo", {31'h0, rdy_o[0]}, 32'd0);
    check("t5 busy", {31'h0, busy_o[0]}, 32'd0);
    check("t5 req", {31'h0, req_o[0]}, 32'd1);
    check("t5 data", d0, 32'h1234_5678);
    ack0 = 1'b1;
    tick();
    check("t5 ready hi", {31'h0, rdy_o[0]}, 32'd1);
    check("t5 data2", d0, 32'h1234_5678);

    // Back-to-back words, zero setup, looped-back acknowledge.
    for (int j = 0; j < 4; j++) words[j] = 16'($urandom);
    begin
      int j;
      int cyc;
      bit acc;
      j = 0;
      cyc = 0;
      vld_i[1] = 1'b1;
      while (j < 4 && cyc < 200) begin
        dat_i[1] = {16'h0, words[j]};
        acc = rdy_o[1];
        tick();
        if (acc) begin
          check("t2 req", {31'h0, req_o[1]}, {31'h0, (j % 2 == 0)});
          check("t2 data", {16'h0, d1}, {16'h0, words[j]});
          j++;
        end
        cyc++;
      end
      vld_i[1] = 1'b0;
      check("t2 words", j, 4);
    end
    repeat (8) tick();
    check("t2 drained", {31'h0, busy_o[1]}, 32'd0);

    // Randomized traffic on all three configurations.
    repeat (3000) begin
      for (int i = 0; i < 3; i++) begin
        rst_i[i] = ($urandom % 64 == 0);
        vld_i[i] = 1'($urandom);
        dat_i[i] = $urandom;
        clr_i[i] = ($urandom % 16 == 0);
      end
      if ($urandom % 4 == 0) ack0 = ~ack0;
      if ($urandom % 3 == 0) ack2 = ~ack2;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cdc_handshake_tx.md
# cdc_handshake_tx

Source-side transmitter of a two-phase (toggle) request/acknowledge handshake that moves a multi-bit word from this clock domain to another. It accepts words on a valid/ready stream, holds each word stable on `cdc_data`, toggles `cdc_req` after a programmable setup delay, and waits for the synchronized acknowledge toggle before accepting the next word. The data and request buses are carried across the domain boundary by `cdc_array_single` instances. The returning acknowledge arrives already synchronized into this domain by another `cdc_array_single`. The matching receiver, `cdc_handshake_rx`, is a separate block.

## Interface
Parameters:
- `WIDTH`, 32: payload width, 1..1024.
- `SETUP_CYCLES`, 2: cycles `cdc_data` is held stable before `cdc_req` toggles, 0..15. Set it to at least the data/req synchronizer skew.
- `ACK_TIMEOUT`, 0: cycles in WAIT_ACK before `timeout` asserts; 0 disables the timeout.

Ports:
- `clk` in 1: the single clock. All logic is rising-edge.
- `rst` in 1: reset, synchronous and active-high.
- `s_valid` in 1: input word valid.
- `s_data` in WIDTH: input word.
- `s_ready` out 1: block can accept a word.
- `cdc_data` out WIDTH: registered payload toward the destination domain.
- `cdc_req` out 1: request toggle level.
- `cdc_ack` in 1: acknowledge toggle level, already synchronized into `clk`.
- `busy` out 1: a transfer is in progress (state is not IDLE).
- `timeout` out 1: sticky flag, the acknowledge is overdue.
- `err_clr` in 1: single-cycle pulse that clears `timeout`.

## Operation
- States: IDLE, SETUP, WAIT_ACK. The state register is the only control storage besides the counters.
- `s_ready` = (state == IDLE) && (`cdc_ack` == `cdc_req`). It is decoded from registered state and the synchronized input only.
- Transitions:
  - Accept when `s_valid && s_ready`. `cdc_data` <= `s_data`.
  - IDLE -> SETUP on accept. If `SETUP_CYCLES` = 0, go IDLE -> WAIT_ACK directly and toggle `cdc_req` on the same edge.
  - SETUP: the setup counter counts `SETUP_CYCLES` edges including the accept edge. On its last edge, toggle `cdc_req` and enter WAIT_ACK.
  - WAIT_ACK -> IDLE on the first edge where sampled `cdc_ack` == `cdc_req`.
- `cdc_data` changes only on an accept edge. `s_data` is ignored at all other times.
- Timeout counter:
  - Clears on entry to WAIT_ACK, increments each cycle in WAIT_ACK, and saturates.
  - When it reaches `ACK_TIMEOUT` (nonzero), `timeout` sets.
  - The transfer is not aborted; the block keeps waiting.
  - `err_clr` clears `timeout`. If a set condition and `err_clr` occur in the same cycle, set wins.
- Reset values: state IDLE, `cdc_req` 0, `cdc_data` 0, `timeout` 0, `busy` 0, counters 0.
- Reset mid-transfer: the in-flight word is dropped and `cdc_req` returns to 0. If the destination was not reset and `cdc_ack` is still 1, `s_ready` stays low until `cdc_ack` returns to 0. No spurious request is issued.
- `cdc_ack` toggling while in IDLE or SETUP is ignored; only the level comparison matters.
- `err_clr` has no effect on the state machine.

## Timing
- With the accept at edge k:
  - `cdc_data` is valid after edge k.
  - `cdc_req` toggles at edge k+`SETUP_CYCLES`.
  - `busy` is high from edge k.
- With the matching `cdc_ack` first sampled at edge m: state is IDLE and `s_ready` is high after edge m, so the next accept can happen at edge m+1.
- Throughput: one word per `SETUP_CYCLES` + 1 + ack round trip, where the round trip is twice the synchronizer depth plus receiver latency.
- `timeout` rises `ACK_TIMEOUT` cycles after WAIT_ACK entry.

## Structure
- Package `cdc_hs_pkg` holds:
  - the `cdc_hs_tx_state_t` enum (IDLE, SETUP, WAIT_ACK);
  - the counter width constants, derived with `$clog2` from `SETUP_CYCLES` and `ACK_TIMEOUT`.
- No sub-module is required. The payload register may be a `dffenr` instance enabled by the accept.

## Test plan
- Single word, `SETUP_CYCLES`=2: after reset, send `s_data`=0xDEADBEEF.
  - Required: `cdc_data`=0xDEADBEEF after edge k, `cdc_req` 0->1 at edge k+2.
  - Then drive `cdc_ack`=1 five cycles later. Required: `s_ready` rises on the next edge.
- Back-to-back, `SETUP_CYCLES`=0: send 4 words with `cdc_ack` looped back through a 3-flop delay.
  - Required: `cdc_req` sequence 1,0,1,0, each word held until its ack, no word lost or repeated.
- Timeout, `ACK_TIMEOUT`=8: never ack.
  - Required: `timeout`=1 exactly 8 cycles after WAIT_ACK entry.
  - Then pulse `err_clr` and `cdc_ack` in the same cycle. Required: `timeout` clears and the state returns to IDLE.
- Reset mid-WAIT_ACK with `cdc_ack` held 1:
  - Required: `cdc_req`=0 and `s_ready`=0 while `cdc_ack`=1.
  - Drop `cdc_ack` to 0. Required: `s_ready`=1 on the next cycle.
- Stray acknowledge toggle in IDLE: toggle `cdc_ack` while `s_valid`=0.
  - Required: `s_ready` tracks the `cdc_ack`==`cdc_req` comparison, `cdc_data` and `cdc_req` do not change, and `busy` stays 0.
